// File: rtl/clk_enable_bank_pkg.sv
// -----------------------------------------------------------------------------
// clk_enable_bank_pkg
// Shared definitions for the programmable clock-enable bank:
//   - register offsets inside one channel's 8-byte slot
//   - register selector enum (CTRL / HALF)
//   - helper that locates the SYNC register after the last channel
// No ports; imported by the interface users, the top and the channel module.
// -----------------------------------------------------------------------------
package clk_enable_bank_pkg;

  localparam int unsigned OFS_CTRL  = 0;
  localparam int unsigned OFS_HALF  = 4;
  localparam int unsigned CH_STRIDE = 8;

  // addr[2] picks the register inside a channel slot (0 -> CTRL, 4 -> HALF)
  typedef enum logic {
    REG_CTRL = 1'b0,
    REG_HALF = 1'b1
  } reg_sel_e;

  // SYNC sits in the slot directly after the last channel
  function automatic logic [31:0] sync_ofs(input int unsigned num_ch);
    return 32'(CH_STRIDE * num_ch);
  endfunction

endpackage

// File: rtl/clk_enable_bank_if.sv
// -----------------------------------------------------------------------------
// clk_enable_bank_if
// CPU peripheral-bus bundle for the clock-enable bank.
//   rd    : read strobe            wr    : write strobe
//   addr  : byte address           wdata : write data
//   rdata : read data, driven by the slave (0 when not addressed)
// master modport = CPU side, slave modport = peripheral side.
// -----------------------------------------------------------------------------
interface clk_enable_bank_if;
  logic        rd;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output rd, output wr, output addr, output wdata, input rdata);
  modport slave  (input rd, input wr, input addr, input wdata, output rdata);
endinterface

// File: rtl/clk_enable_bank_div_channel.sv
// -----------------------------------------------------------------------------
// clk_enable_bank_div_channel
// One divider channel: enable bit, pending/active half-period, counter,
// registered one-cycle enable pulse and 50%-duty toggle.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   i_en_we/i_en_wd   : CTRL.EN write strobe / data
//   i_half_we/i_half_wd : HALF write strobe / data (updates pending only)
//   i_sync            : bank-wide phase-align pulse
//   o_en, o_pending, o_count : register read-back
//   o_ce, o_tick      : enable pulse at terminal count, toggle output
// -----------------------------------------------------------------------------
module clk_enable_bank_div_channel #(
  parameter int   DIV_W        = 16,
  parameter int   DEFAULT_HALF = 4,
  parameter logic RST_EN_BIT   = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_en_we,
  input  logic             i_en_wd,
  input  logic             i_half_we,
  input  logic [DIV_W-1:0] i_half_wd,
  input  logic             i_sync,
  output logic             o_en,
  output logic [DIV_W-1:0] o_pending,
  output logic [DIV_W-1:0] o_count,
  output logic             o_ce,
  output logic             o_tick
);

  logic             r_en;
  logic [DIV_W-1:0] r_pending;
  logic [DIV_W-1:0] r_active;
  logic [DIV_W-1:0] r_count;
  logic             r_ce;
  logic             r_tick;

  // Post-write views: a write landing on the same edge as a terminal count
  // or SYNC is the value that gets loaded.
  logic             w_en_nxt;
  logic [DIV_W-1:0] w_pending_nxt;

  assign w_en_nxt      = i_en_we   ? i_en_wd   : r_en;
  assign w_pending_nxt = i_half_we ? i_half_wd : r_pending;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_en      <= RST_EN_BIT;
      r_pending <= DIV_W'(DEFAULT_HALF);
      r_active  <= DIV_W'(DEFAULT_HALF);
      r_count   <= '0;
      r_ce      <= 1'b0;
      r_tick    <= 1'b0;
    end else begin
      r_en      <= w_en_nxt;
      r_pending <= w_pending_nxt;
      if (i_sync) begin
        r_count  <= '0;
        r_tick   <= 1'b0;
        r_ce     <= 1'b0;
        r_active <= w_pending_nxt;
      end else if (!r_en || !w_en_nxt) begin
        // Disabled, or on the enable/disable edge itself: hold at zero and
        // let the divisor follow pending so re-enable starts on the new ratio.
        r_count  <= '0;
        r_tick   <= 1'b0;
        r_ce     <= 1'b0;
        r_active <= w_pending_nxt;
      end else if (r_count >= r_active) begin
        // >= rather than == keeps the counter bounded even if active shrank
        r_count  <= '0;
        r_ce     <= 1'b1;
        r_tick   <= ~r_tick;
        r_active <= w_pending_nxt;
      end else begin
        r_count  <= r_count + DIV_W'(1);
        r_ce     <= 1'b0;
      end
    end
  end

  assign o_en      = r_en;
  assign o_pending = r_pending;
  assign o_count   = r_count;
  assign o_ce      = r_ce;
  assign o_tick    = r_tick;

endmodule

// File: rtl/clk_enable_bank.sv
// -----------------------------------------------------------------------------
// clk_enable_bank
// Bus-programmable bank of NUM_CH clock-enable dividers.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   bus        : peripheral bus slave (rd/wr/addr/wdata/rdata)
//   ce         : per-channel one-cycle enable pulse at terminal count
//   tick       : per-channel toggle, period 2*(HALF+1) cycles
// Map: BASE+8c+0 CTRL (bit0 EN), BASE+8c+4 HALF (pending, live count in
// [31:16] when DIV_W<=16), BASE+8*NUM_CH SYNC (write bit0=1, reads 0).
// rdata is 0 unless rd is high and the address hits a channel register, so
// it can be ORed straight into the CPU read mux.
// -----------------------------------------------------------------------------
module clk_enable_bank
  import clk_enable_bank_pkg::*;
#(
  parameter int                NUM_CH       = 4,
  parameter int                DIV_W        = 16,
  parameter logic [31:0]       BASE_ADDR    = 32'h4000_0040,
  parameter int                DEFAULT_HALF = 4,
  parameter logic [NUM_CH-1:0] RST_EN       = {NUM_CH{1'b1}}
) (
  input  logic                clk,
  input  logic                reset,
  clk_enable_bank_if.slave    bus,
  output logic [NUM_CH-1:0]   ce,
  output logic [NUM_CH-1:0]   tick
);

  localparam logic [31:0] SYNC_OFS = sync_ofs(NUM_CH);

  logic [31:0] w_off;
  logic        w_above;
  logic        w_in_ch;
  logic        w_is_sync;
  logic        w_sync;
  reg_sel_e    w_reg;
  logic [31:0] w_rdata;
  logic        w_unused;

  logic [NUM_CH-1:0] w_en_we;
  logic [NUM_CH-1:0] w_half_we;
  logic [NUM_CH-1:0] w_en;
  logic [DIV_W-1:0]  w_pending [NUM_CH];
  logic [DIV_W-1:0]  w_count   [NUM_CH];
  logic [31:0]       w_half_rd [NUM_CH];

  // Offset from BASE; the lower bound check rejects wrapped subtractions
  assign w_off     = bus.addr - BASE_ADDR;
  assign w_above   = (bus.addr >= BASE_ADDR);
  assign w_in_ch   = w_above && (w_off < SYNC_OFS);
  assign w_is_sync = w_above && (w_off[31:2] == SYNC_OFS[31:2]);
  assign w_reg     = reg_sel_e'(w_off[2]);
  assign w_sync    = bus.wr && w_is_sync && bus.wdata[0];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic w_sel;
    assign w_sel        = w_in_ch && (w_off[31:3] == 29'(c));
    assign w_en_we[c]   = bus.wr && w_sel && (w_reg == REG_CTRL);
    assign w_half_we[c] = bus.wr && w_sel && (w_reg == REG_HALF);

    clk_enable_bank_div_channel #(
      .DIV_W        (DIV_W),
      .DEFAULT_HALF (DEFAULT_HALF),
      .RST_EN_BIT   (RST_EN[c])
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .i_en_we   (w_en_we[c]),
      .i_en_wd   (bus.wdata[0]),
      .i_half_we (w_half_we[c]),
      .i_half_wd (bus.wdata[DIV_W-1:0]),
      .i_sync    (w_sync),
      .o_en      (w_en[c]),
      .o_pending (w_pending[c]),
      .o_count   (w_count[c]),
      .o_ce      (ce[c]),
      .o_tick    (tick[c])
    );

    // Live count only fits beside the divisor when the divisor is <=16 bits
    if (DIV_W <= 16) begin : g_cnt_rd
      assign w_half_rd[c] = {16'(w_count[c]), 16'(w_pending[c])};
    end else begin : g_no_cnt_rd
      assign w_half_rd[c] = 32'(w_pending[c]);
    end
  end

  always_comb begin
    w_rdata = '0;
    if (bus.rd && !reset && w_in_ch) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (w_off[31:3] == 29'(c)) begin
          w_rdata = w_rdata | ((w_reg == REG_CTRL) ? {31'b0, w_en[c]} : w_half_rd[c]);
        end
      end
    end
  end

  assign bus.rdata = w_rdata;

  // Address byte lane and upper write-data bits are intentionally ignored
  assign w_unused = ^{w_off[1:0], bus.wdata};

endmodule

// File: tb/tb_clk_enable_bank.sv
// -----------------------------------------------------------------------------
// tb_clk_enable_bank
// Directed bench for clk_enable_bank with default parameters (4 channels,
// HALF=4 after reset, BASE=0x4000_0040). cyc counts rising edges since the
// current reset release; expected pulse positions are written in those terms.
// -----------------------------------------------------------------------------
module tb_clk_enable_bank;

  localparam logic [31:0] BASE = 32'h4000_0040;

  logic       clk;
  logic       reset;
  logic [3:0] ce;
  logic [3:0] tick;

  int checks;
  int errors;
  int cyc;

  clk_enable_bank_if bus_if ();

  clk_enable_bank dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if),
    .ce    (ce),
    .tick  (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    bus_if.wr    = 1'b1;
    bus_if.addr  = a;
    bus_if.wdata = d;
    step();
    bus_if.wr    = 1'b0;
    bus_if.wdata = '0;
  endtask

  task automatic bus_rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    bus_if.rd   = 1'b1;
    bus_if.addr = a;
    #1;
    chk(tag, bus_if.rdata, exp);
    bus_if.rd   = 1'b0;
  endtask

  initial begin
    logic [3:0] e;
    checks = 0;
    errors = 0;
    cyc    = 0;
    bus_if.rd    = 1'b0;
    bus_if.wr    = 1'b0;
    bus_if.addr  = '0;
    bus_if.wdata = '0;
    reset = 1'b1;

    // 1: reset state and default divide-by-10
    step();
    step();
    chk("rst_ce", 32'(ce), 32'h0);
    chk("rst_tick", 32'(tick), 32'h0);
    bus_rd("rst_rd_ignored", BASE + 32'd4, 32'h0);
    reset = 1'b0;
    cyc = 0;
    bus_if.addr = BASE + 32'd4;
    #1;
    chk("rd0_rdata", bus_if.rdata, 32'h0);
    for (int n = 1; n <= 40; n++) begin
      step();
      chk("p1_ce", 32'(ce), (cyc % 5 == 0) ? 32'hF : 32'h0);
      chk("p1_tick", 32'(tick), (((cyc / 5) % 2) == 1) ? 32'hF : 32'h0);
    end

    // 2: HALF(ch1)=2 while count=1; running period still ends at count 4
    step();                                   // cyc 41, ch1 count=1
    bus_wr(BASE + 32'd12, 32'd2);             // cyc 42
    while (cyc < 55) begin
      step();
      e[0] = (cyc % 5 == 0);
      e[1] = (cyc == 45) || (cyc == 48) || (cyc == 51) || (cyc == 54);
      e[2] = (cyc % 5 == 0);
      e[3] = (cyc % 5 == 0);
      chk("p2_ce", 32'(ce), 32'(e));
    end
    chk("p2_tick", 32'(tick), 32'hD);

    // 3: disable then re-enable ch2
    step();                                   // cyc 56
    bus_wr(BASE + 32'd16, 32'd0);             // cyc 57
    chk("p3_dis_ce2", 32'(ce[2]), 32'h0);
    chk("p3_dis_tick2", 32'(tick[2]), 32'h0);
    step();
    step();                                   // cyc 59
    chk("p3_hold_tick2", 32'(tick[2]), 32'h0);
    bus_wr(BASE + 32'd16, 32'd1);             // cyc 60
    chk("p3_en_ce0", 32'(ce[0]), 32'h1);
    chk("p3_en_ce2", 32'(ce[2]), 32'h0);
    while (cyc < 65) begin
      step();
      chk("p3_ce2", 32'(ce[2]), (cyc == 65) ? 32'h1 : 32'h0);
    end
    chk("p3_tick2", 32'(tick[2]), 32'h1);

    // 4: HALF ch0=0, ch3=7, then SYNC
    bus_wr(BASE + 32'd4, 32'd0);              // cyc 66
    bus_wr(BASE + 32'd28, 32'd7);             // cyc 67
    chk("p4_pending_ce0", 32'(ce[0]), 32'h0);
    bus_wr(BASE + 32'd32, 32'd1);             // cyc 68
    chk("p4_sync_tick", 32'(tick), 32'h0);
    chk("p4_sync_ce", 32'(ce), 32'h0);
    while (cyc < 76) begin
      step();
      e[0] = 1'b1;
      e[1] = (cyc == 71) || (cyc == 74);
      e[2] = (cyc == 73);
      e[3] = (cyc == 76);
      chk("p4_ce", 32'(ce), 32'(e));
      chk("p4_tick0", 32'(tick[0]), 32'((cyc - 68) % 2));
    end

    // 5: reads (combinational, no clock)
    bus_rd("p5_half2", BASE + 32'h14, 32'h0003_0004);
    bus_rd("p5_half1", BASE + 32'h0C, 32'h0002_0002);
    bus_rd("p5_ctrl2", BASE + 32'h10, 32'h0000_0001);
    bus_rd("p5_sync", BASE + 32'h20, 32'h0);
    bus_rd("p5_outwin", 32'h4000_0000, 32'h0);
    bus_if.addr = BASE + 32'h14;
    #1;
    chk("p5_rd0", bus_if.rdata, 32'h0);

    // 6: reset while ch1 count=2
    reset = 1'b1;
    bus_rd("p6_rst_rd", BASE + 32'h14, 32'h0);
    step();
    chk("p6_ce", 32'(ce), 32'h0);
    chk("p6_tick", 32'(tick), 32'h0);
    reset = 1'b0;
    cyc = 0;
    bus_rd("p6_half0", BASE + 32'd4, 32'h0000_0004);
    bus_rd("p6_half3", BASE + 32'd28, 32'h0000_0004);
    bus_rd("p6_ctrl2", BASE + 32'd16, 32'h0000_0001);
    for (int n = 1; n <= 5; n++) begin
      step();
      chk("p6_ce_run", 32'(ce), (cyc == 5) ? 32'hF : 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
